add_post_norm_seq: RTL

- Sequential post-normalisation and rounding stage for the single-precision add/sub path.
- Consumes the aligned 28-bit sum/difference and the larger operand's exponent produced downstream of pre-normalisation and the adder.
- Produces a packed IEEE-754 single result plus flags.
- Left normalisation is iterative (one bit per cycle) under a valid/ready handshake; it is the inverse of the alignment done before the adder.

---
 rtl/add_post_norm_seq_if.sv | 31 +++
 rtl/add_post_norm_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/add_post_norm_seq_if.sv
// Handshake and operand/result bundle for the add/sub post-normalisation stage.
// The slave side is the normaliser; the master side feeds operands and consumes results.
interface add_post_norm_seq_if #(
  parameter int FRAC_W = 28,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [FRAC_W-1:0] fract_in;
  logic [EXP_W-1:0]  exp_in;
  logic              sign_in;
  logic              zero_sign;
  logic [1:0]        rmode;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out;
  logic              ine;
  logic              overflow;
  logic              underflow;
  logic              zero;

  modport slave (
    input  in_valid, fract_in, exp_in, sign_in, zero_sign, rmode, out_ready,
    output in_ready, out_valid, out, ine, overflow, underflow, zero
  );

  modport master (
    output in_valid, fract_in, exp_in, sign_in, zero_sign, rmode, out_ready,
    input  in_ready, out_valid, out, ine, overflow, underflow, zero
  );
endinterface

// File: rtl/add_post_norm_seq.sv
// Sequential post-normalisation and rounding for the single-precision add/sub path.
// Left normalisation runs one bit per cycle; rounding and packing take one more cycle.
// fract layout: carry(27) hidden(26) mantissa(25:3) guard(2) round(1) sticky(0).
module add_post_norm_seq #(
  parameter int FRAC_W = 28,
  parameter int EXP_W  = 8
) (
  input logic              clk,
  input logic              rst_n,
  add_post_norm_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  localparam logic [EXP_W:0] E_ONE = 1;
  localparam logic [EXP_W:0] E_TWO = 2;
  localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};

  state_t            state, state_nxt;
  logic [FRAC_W-1:0] f, f_nxt;
  logic [EXP_W:0]    e, e_nxt;
  logic              sgn, zsgn;
  logic [1:0]        rm;

  logic [23:0]       m;
  logic              inexact, inc, to_inf;
  logic [24:0]       m_sum;
  logic [23:0]       m_fin;
  logic [EXP_W:0]    e_fin;
  logic [EXP_W-1:0]  field;
  logic [31:0]       res_c;
  logic              ine_c, ovf_c, unf_c, zero_c;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);

  // State, working operand and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      f             <= '0;
      e             <= '0;
      sgn           <= 1'b0;
      zsgn          <= 1'b0;
      rm            <= '0;
      bus.out       <= '0;
      bus.ine       <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
      bus.zero      <= 1'b0;
    end else begin
      state <= state_nxt;
      f     <= f_nxt;
      e     <= e_nxt;
      if (state == IDLE && bus.in_valid) begin
        sgn  <= bus.sign_in;
        zsgn <= bus.zero_sign;
        rm   <= bus.rmode;
      end
      if (state == ROUND) begin
        bus.out       <= res_c;
        bus.ine       <= ine_c;
        bus.overflow  <= ovf_c;
        bus.underflow <= unf_c;
        bus.zero      <= zero_c;
      end
    end
  end

  // Next state and one normalisation step per SHIFT cycle.
  always_comb begin
    state_nxt = state;
    f_nxt     = f;
    e_nxt     = e;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          f_nxt     = bus.fract_in;
          e_nxt     = {1'b0, bus.exp_in};
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (f[27]) begin
          f_nxt     = {1'b0, f[27:2], f[1] | f[0]};
          e_nxt     = e + E_ONE;
          state_nxt = ROUND;
        end else if (f == '0) begin
          state_nxt = ROUND;
        end else if (!f[26] && e > E_ONE) begin
          f_nxt = {f[26:0], 1'b0};
          e_nxt = e - E_ONE;
          // Leave as soon as this shift normalises or reaches e==1, rather than
          // spending an idle SHIFT cycle rediscovering it; the result is unchanged.
          state_nxt = (f[25] || e == E_TWO) ? ROUND : SHIFT;
        end else begin
          state_nxt = ROUND;
        end
      end
      ROUND: state_nxt = DONE;
      DONE:  if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rounding, overflow saturation and result packing from the normalised operand.
  always_comb begin
    m       = f[26:3];
    inexact = f[2] | f[1] | f[0];
    case (rm)
      2'd0:    inc = f[2] & (f[1] | f[0] | m[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = inexact & ~sgn;
      default: inc = inexact & sgn;
    endcase
    m_sum = {1'b0, m} + {24'b0, inc};
    if (m_sum[24]) begin
      m_fin = m_sum[24:1];
      e_fin = e + E_ONE;
    end else begin
      m_fin = m_sum[23:0];
      e_fin = e;
    end
    field  = m_fin[23] ? e_fin[EXP_W-1:0] : '0;
    to_inf = (rm == 2'd0) || (rm == 2'd2 && !sgn) || (rm == 2'd3 && sgn);
    zero_c = (f == '0);
    ovf_c  = 1'b0;
    ine_c  = inexact;
    unf_c  = 1'b0;
    if (zero_c) begin
      res_c = {zsgn, 31'b0};
      ine_c = 1'b0;
    end else if (e_fin >= E_MAX) begin
      ovf_c = 1'b1;
      ine_c = 1'b1;
      res_c = to_inf ? {sgn, 8'hFF, 23'b0} : {sgn, 31'h7F7F_FFFF};
    end else begin
      res_c = {sgn, field, m_fin[22:0]};
      unf_c = (field == '0) && inexact;
    end
  end

endmodule
